regfile_wb_arbiter: RTL

//  Shares the register file's single write port (we3/a3/wd3) between NREQ writeback requesters (e.g. ALU, load unit).

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_if.sv | 17 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register-file writeback path.
//   XLEN  : data width
//   AW    : register address width
//   NREG  : number of architectural registers (x0 reads as zero)
//   wb_req_t : one writeback request (destination + data)
package regfile_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 2 ** AW;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wb_req_t;

   // Modular add used for round-robin index arithmetic.
   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b) % n;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bundle: NREQ requesters, each with valid/ready,
// destination address and write data packed side by side.
//   master : requester side (drives valid/addr/data, sees ready)
//   slave  : arbiter side (sees valid/addr/data, drives ready)
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 2,
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*XLEN-1:0] req_data;

   modport master (output req_valid, output req_addr, output req_data, input req_ready);
   modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin picker: starting at ptr, grants the first asserted request.
//   req   in  N    request vector
//   ptr   in  PW   highest-priority index this cycle
//   grant out N    one-hot winner (all zero when no request)
//   idx   out PW   index of the winner (0 when none)
//   any   out 1    a winner exists
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);
   import regfile_pkg::*;

   // Scan from ptr upward (wrapping); the first hit claims the grant.
   always_comb begin
      grant = {N{1'b0}};
      idx   = {PW{1'b0}};
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         int  c;
         logic hit;
         c        = wrap_add(int'(ptr), k, N);
         hit      = !any && req[c];
         grant[c] = grant[c] | hit;
         idx      = hit ? PW'(c) : idx;
         any      = any | hit;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NREQ writeback requesters
// with round-robin priority, and tracks a per-register busy scoreboard.
//   clk, rst_n   clock, asynchronous active-low reset
//   wb           requester bundle (valid/ready/addr/data), slave side
//   wb_stall     blocks all grants while high
//   claim_valid  issue stage reserves claim_addr
//   claim_addr   register being reserved
//   claim_err    registered pulse: claim hit an already-busy register
//   busy         scoreboard, bit 0 always 0
//   we3/a3/wd3   registered register-file write port
module regfile_wb_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wb_arbiter_if.slave wb,
   input  logic                wb_stall,
   input  logic                claim_valid,
   input  logic [AW-1:0]       claim_addr,
   output logic                claim_err,
   output logic [2**AW-1:0]    busy,
   output logic                we3,
   output logic [AW-1:0]       a3,
   output logic [XLEN-1:0]     wd3
);
   import regfile_pkg::*;

   localparam int NR = 2 ** AW;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic [PW-1:0]   rr_ptr;
   logic [AW-1:0]   win_addr;
   logic [XLEN-1:0] win_data;
   logic            claim_live;
   logic            clearing;
   logic            claim_err_nxt;
   logic [NR-1:0]   busy_nxt;

   // Reset is included so ready drops the moment rst_n falls, not at the next edge.
   assign arb_req = (wb_stall || !rst_n) ? {NREQ{1'b0}} : wb.req_valid;

   rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
      .req   (arb_req),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   assign wb.req_ready = grant;

   // Select the winning requester's address and data.
   always_comb begin
      win_addr = wb.req_addr[int'(grant_idx)*AW +: AW];
      win_data = wb.req_data[int'(grant_idx)*XLEN +: XLEN];
   end

   // Round-robin pointer: the requester after the winner gets top priority next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= {PW{1'b0}};
      end else if (grant_any) begin
         rr_ptr <= PW'(wrap_add(int'(grant_idx), 1, NREQ));
      end else begin
         rr_ptr <= rr_ptr;
      end
   end

   // Write port register; x0 writes are accepted but never raise we3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3 <= 1'b0;
         a3  <= {AW{1'b0}};
         wd3 <= {XLEN{1'b0}};
      end else if (grant_any) begin
         we3 <= (win_addr != {AW{1'b0}});
         a3  <= win_addr;
         wd3 <= win_data;
      end else begin
         we3 <= 1'b0;
      end
   end

   // Scoreboard next state: commit clears first, then a claim sets (set wins).
   always_comb begin
      claim_live = claim_valid && (claim_addr != {AW{1'b0}});
      clearing   = we3 && (a3 == claim_addr);
      busy_nxt   = busy;
      if (we3) begin
         busy_nxt[a3] = 1'b0;
      end else begin
         busy_nxt[a3] = busy[a3];
      end
      if (claim_live) begin
         busy_nxt[claim_addr] = 1'b1;
      end else begin
         busy_nxt[claim_addr] = busy_nxt[claim_addr];
      end
      busy_nxt[0]   = 1'b0;
      // A register being released this very cycle is not a conflict.
      claim_err_nxt = claim_live && busy[claim_addr] && !clearing;
   end

   // Scoreboard and claim-error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= {NR{1'b0}};
         claim_err <= 1'b0;
      end else begin
         busy      <= busy_nxt;
         claim_err <= claim_err_nxt;
      end
   end

endmodule
